hdmi_video_timing: RTL and testbench
====================================

Name: hdmi_video_timing

Overview:
Downstream pixel-output stage of the HDMI controller. It generates raster timing (DE/HSYNC/VSYNC) from programmable horizontal and vertical parameters. During active video it pops 36-bit pixels from the upstream frame-fetch FIFO over a valid/ready handshake and drives the HDMI transmitter pins. The pixel clock is ACLK. It reports frame-start and underrun events to the register/interrupt logic.

Parameters:
TW, 12, width of every timing field and of the h/v counters
DW, 36, pixel data width
UNDERRUN_COLOR, 36'h0, pixel value driven when the FIFO is empty during active video

Ports:
ACLK  in  1  clock (pixel clock)
nRST  in  1  reset, synchronous, active-low
EN  in  1  timing enable; sampled only at frame boundary
H_ACTIVE  in  TW  active pixels per line, ≥1
H_FP  in  TW  horizontal front porch, ≥0
H_SYNC  in  TW  hsync width, ≥1
H_BP  in  TW  horizontal back porch, ≥0
V_ACTIVE  in  TW  active lines, ≥1
V_FP  in  TW  vertical front porch lines, ≥0
V_SYNC  in  TW  vsync width in lines, ≥1
V_BP  in  TW  vertical back porch lines, ≥0
H_POL  in  1  1 = hsync active-high
V_POL  in  1  1 = vsync active-high
PIX_VALID  in  1  upstream pixel available
PIX_DATA  in  DW  upstream pixel
PIX_READY  out  1  pop strobe to upstream FIFO
HDMI_DE  out  1  data enable
HDMI_HSYNC  out  1  horizontal sync
HDMI_VSYNC  out  1  vertical sync
HDMI_DATA  out  DW  pixel output
FRAME_START  out  1  one-cycle pulse, first active pixel of each frame
UNDERRUN  out  1  one-cycle pulse per empty-FIFO active pixel
BUSY  out  1  1 while a frame is in progress

Behaviour:
- Reset (nRST=0 at a rising ACLK edge): h_cnt=v_cnt=0; state IDLE; all outputs 0.
- States: IDLE and RUN. IDLE->RUN when EN=1 at the clock edge. RUN->IDLE at the end of a frame (last cycle of last line) when EN=0; otherwise the next frame starts back-to-back. Deasserting EN mid-frame has no effect until the frame ends.
- On each IDLE->RUN or frame wrap, latch all timing and polarity inputs into shadow registers. Mid-frame input changes are ignored.
- Line layout, h_cnt 0..H_TOTAL-1, H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP: active [0,H_ACTIVE), front porch, sync, back porch.
- Frame layout uses v_cnt 0..V_TOTAL-1 with the same ordering. v_cnt increments when h_cnt wraps to 0. v_cnt wraps to 0 after V_TOTAL-1. Internal sums are TW+2 bits wide; no overflow.
- hsync region is active on every line, including vertical blanking. VSYNC transitions align to h_cnt=0.
- PIX_READY is combinational: 1 iff state=RUN and the counters are in an active pixel and PIX_VALID=1. The pop occurs on that cycle.
- Output latency is 1 cycle, all registered:
  - HDMI_DE = active region of the previous counter value.
  - HDMI_DATA = PIX_DATA if popped, UNDERRUN_COLOR if active with no pixel, 0 outside active.
  - HDMI_HSYNC/HDMI_VSYNC = H_POL/V_POL when in the sync region, otherwise the inverted polarity.
- IDLE outputs: DE=0, DATA=0, syncs at the inactive level of the current (unlatched) H_POL/V_POL.
- UNDERRUN pulses on the same cycle as the DE it affects. Counters never stall on underrun; timing is free-running.
- FRAME_START is asserted together with HDMI_DE for h=0, v=0.
- BUSY=1 in RUN, 0 in IDLE.
- Mid-operation reset: return to IDLE and zero outputs on the next edge. The upstream FIFO is not popped during reset.

Test Plan:
- Config H 4/1/2/1, V 3/1/1/1, polarities 1, EN=1, PIX_VALID=1 with an incrementing pattern -> 48-cycle frame. DE is high 4 of every 8 cycles on lines 0-2. HSYNC is high at h=5,6 (+1 latency) on all 6 lines. VSYNC is high for all 8 cycles of line 4. DATA sequence is 0..11. FRAME_START fires once per 48 cycles.
- Same config, H_POL=V_POL=0 -> sync waveforms are inverted; idle before EN drives HSYNC=VSYNC=1.
- PIX_VALID=0 for pixel (1,2) only -> no pop that cycle, DATA=UNDERRUN_COLOR, UNDERRUN is a single pulse, the next pixel uses the next FIFO word, timing is unchanged.
- Drop EN at h=3,v=1 -> frame completes all 48 cycles, then IDLE, BUSY=0, no further PIX_READY.
- Change H_ACTIVE 4->6 mid-frame -> current frame is unchanged, the next frame has a 10-cycle line (60-cycle frame).
- Assert nRST=0 at h=2,v=0 for 1 cycle -> next cycle all outputs are 0 and PIX_READY=0. The frame restarts from h=0,v=0 once EN is seen high.

Source files
------------

// File: rtl/hdmi_video_timing.sv
// HDMI pixel-output stage: raster timing generator with a valid/ready pixel pop.
// Timing parameters are captured into shadow registers at every frame start.
// DE/HSYNC/VSYNC/DATA and the event pulses are registered, so they lag the
// counters by one cycle. PIX_READY is combinational from the current counters.
module hdmi_video_timing #(
    parameter int unsigned      TW             = 12,
    parameter int unsigned      DW             = 36,
    parameter logic [DW-1:0]    UNDERRUN_COLOR = '0
) (
    input  logic          ACLK,
    input  logic          nRST,
    input  logic          EN,
    input  logic [TW-1:0] H_ACTIVE,
    input  logic [TW-1:0] H_FP,
    input  logic [TW-1:0] H_SYNC,
    input  logic [TW-1:0] H_BP,
    input  logic [TW-1:0] V_ACTIVE,
    input  logic [TW-1:0] V_FP,
    input  logic [TW-1:0] V_SYNC,
    input  logic [TW-1:0] V_BP,
    input  logic          H_POL,
    input  logic          V_POL,
    input  logic          PIX_VALID,
    input  logic [DW-1:0] PIX_DATA,
    output logic          PIX_READY,
    output logic          HDMI_DE,
    output logic          HDMI_HSYNC,
    output logic          HDMI_VSYNC,
    output logic [DW-1:0] HDMI_DATA,
    output logic          FRAME_START,
    output logic          UNDERRUN,
    output logic          BUSY
);

    // Region boundaries are summed two bits wider than a field so that four
    // maximal fields cannot overflow.
    localparam int unsigned SW = TW + 2;

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } state_e;

    state_e state_q, state_d;

    logic [TW-1:0] h_cnt_q, h_cnt_d;
    logic [TW-1:0] v_cnt_q, v_cnt_d;

    // Shadow copies of the timing inputs, stable for a whole frame
    logic [TW-1:0] h_active_q, h_fp_q, h_sync_q, h_bp_q;
    logic [TW-1:0] v_active_q, v_fp_q, v_sync_q, v_bp_q;
    logic          h_pol_q, v_pol_q;

    // Registered output stage
    logic          de_q, de_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic [DW-1:0] data_q, data_d;
    logic          fs_q, fs_d;
    logic          ur_q, ur_d;

    // Region boundaries (start of front porch, sync, back porch; line/frame total)
    logic [SW-1:0] h_fp_start, h_sync_start, h_bp_start, h_total;
    logic [SW-1:0] v_fp_start, v_sync_start, v_bp_start, v_total;
    logic [SW-1:0] h_cnt_x, v_cnt_x;

    logic running;
    logic h_act, v_act, h_in_sync, v_in_sync;
    logic h_last, v_last;
    logic frame_end;
    logic load_shadow;
    logic pix_active;

    assign h_fp_start   = {2'b00, h_active_q};
    assign h_sync_start = h_fp_start + {2'b00, h_fp_q};
    assign h_bp_start   = h_sync_start + {2'b00, h_sync_q};
    assign h_total      = h_bp_start + {2'b00, h_bp_q};

    assign v_fp_start   = {2'b00, v_active_q};
    assign v_sync_start = v_fp_start + {2'b00, v_fp_q};
    assign v_bp_start   = v_sync_start + {2'b00, v_sync_q};
    assign v_total      = v_bp_start + {2'b00, v_bp_q};

    assign h_cnt_x = {2'b00, h_cnt_q};
    assign v_cnt_x = {2'b00, v_cnt_q};

    assign running   = (state_q == StRun);
    assign h_act     = (h_cnt_x < h_fp_start);
    assign v_act     = (v_cnt_x < v_fp_start);
    assign h_in_sync = (h_cnt_x >= h_sync_start) && (h_cnt_x < h_bp_start);
    assign v_in_sync = (v_cnt_x >= v_sync_start) && (v_cnt_x < v_bp_start);
    assign h_last    = (h_cnt_x == h_total - SW'(1));
    assign v_last    = (v_cnt_x == v_total - SW'(1));
    assign frame_end = running && h_last && v_last;

    // Shadows reload on leaving IDLE and on a back-to-back frame wrap
    assign load_shadow = EN && ((state_q == StIdle) || frame_end);

    assign pix_active = running && h_act && v_act;

    // The FIFO must never be popped while reset is held, even though state is
    // still RUN until the reset edge lands.
    assign PIX_READY = nRST && pix_active && PIX_VALID;

    assign HDMI_DE     = de_q;
    assign HDMI_HSYNC  = hsync_q;
    assign HDMI_VSYNC  = vsync_q;
    assign HDMI_DATA   = data_q;
    assign FRAME_START = fs_q;
    assign UNDERRUN    = ur_q;
    assign BUSY        = running;

    // Next-state and counter advance; EN is only consulted at frame boundaries
    always_comb begin
        state_d = state_q;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        unique case (state_q)
            StIdle: begin
                h_cnt_d = '0;
                v_cnt_d = '0;
                if (EN) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (h_last) begin
                    h_cnt_d = '0;
                    if (v_last) begin
                        v_cnt_d = '0;
                        if (!EN) begin
                            state_d = StIdle;
                        end
                    end else begin
                        v_cnt_d = v_cnt_q + TW'(1);
                    end
                end else begin
                    h_cnt_d = h_cnt_q + TW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                h_cnt_d = '0;
                v_cnt_d = '0;
            end
        endcase
    end

    // Output values for the current counter position, registered next edge.
    // IDLE parks the syncs at the inactive level of the live polarity inputs.
    always_comb begin
        de_d    = 1'b0;
        hsync_d = ~H_POL;
        vsync_d = ~V_POL;
        data_d  = '0;
        fs_d    = 1'b0;
        ur_d    = 1'b0;
        if (running) begin
            hsync_d = h_in_sync ? h_pol_q : ~h_pol_q;
            vsync_d = v_in_sync ? v_pol_q : ~v_pol_q;
            if (h_act && v_act) begin
                de_d = 1'b1;
                fs_d = (h_cnt_q == '0) && (v_cnt_q == '0);
                if (PIX_VALID) begin
                    data_d = PIX_DATA;
                end else begin
                    data_d = UNDERRUN_COLOR;
                    ur_d   = 1'b1;
                end
            end
        end
    end

    // State, counters and output registers with synchronous reset
    always_ff @(posedge ACLK) begin
        if (!nRST) begin
            state_q <= StIdle;
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            de_q    <= 1'b0;
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
            data_q  <= '0;
            fs_q    <= 1'b0;
            ur_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            de_q    <= de_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            data_q  <= data_d;
            fs_q    <= fs_d;
            ur_q    <= ur_d;
        end
    end

    // Shadow timing registers, captured at each frame start
    always_ff @(posedge ACLK) begin
        if (!nRST) begin
            h_active_q <= '0;
            h_fp_q     <= '0;
            h_sync_q   <= '0;
            h_bp_q     <= '0;
            v_active_q <= '0;
            v_fp_q     <= '0;
            v_sync_q   <= '0;
            v_bp_q     <= '0;
            h_pol_q    <= 1'b0;
            v_pol_q    <= 1'b0;
        end else if (load_shadow) begin
            h_active_q <= H_ACTIVE;
            h_fp_q     <= H_FP;
            h_sync_q   <= H_SYNC;
            h_bp_q     <= H_BP;
            v_active_q <= V_ACTIVE;
            v_fp_q     <= V_FP;
            v_sync_q   <= V_SYNC;
            v_bp_q     <= V_BP;
            h_pol_q    <= H_POL;
            v_pol_q    <= V_POL;
        end
    end

endmodule

// File: tb/tb_hdmi_video_timing.sv
// Directed bench for hdmi_video_timing: small 8x6 raster, FIFO model on
// PIX_READY, expected outputs computed from the configured raster geometry.
module tb_hdmi_video_timing;

    localparam logic [35:0] UC = 36'hA5A50F0F0;

    logic        ACLK;
    logic        nRST;
    logic        EN;
    logic [11:0] H_ACTIVE, H_FP, H_SYNC, H_BP;
    logic [11:0] V_ACTIVE, V_FP, V_SYNC, V_BP;
    logic        H_POL, V_POL;
    logic        PIX_VALID;
    logic [35:0] PIX_DATA;
    logic        PIX_READY;
    logic        HDMI_DE, HDMI_HSYNC, HDMI_VSYNC;
    logic [35:0] HDMI_DATA;
    logic        FRAME_START, UNDERRUN, BUSY;

    int checks = 0;
    int errors = 0;

    // FIFO model and expected-value state
    logic [35:0] pix_word;
    logic [35:0] exp_word;
    int          n_pops;
    int e_ha, e_hfp, e_hs, e_hbp, e_va, e_vfp, e_vs, e_vbp;
    logic e_hp, e_vp;

    hdmi_video_timing #(
        .TW(12),
        .DW(36),
        .UNDERRUN_COLOR(UC)
    ) dut (
        .ACLK(ACLK),
        .nRST(nRST),
        .EN(EN),
        .H_ACTIVE(H_ACTIVE),
        .H_FP(H_FP),
        .H_SYNC(H_SYNC),
        .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE),
        .V_FP(V_FP),
        .V_SYNC(V_SYNC),
        .V_BP(V_BP),
        .H_POL(H_POL),
        .V_POL(V_POL),
        .PIX_VALID(PIX_VALID),
        .PIX_DATA(PIX_DATA),
        .PIX_READY(PIX_READY),
        .HDMI_DE(HDMI_DE),
        .HDMI_HSYNC(HDMI_HSYNC),
        .HDMI_VSYNC(HDMI_VSYNC),
        .HDMI_DATA(HDMI_DATA),
        .FRAME_START(FRAME_START),
        .UNDERRUN(UNDERRUN),
        .BUSY(BUSY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // One clock: note whether the FIFO is popped, then advance it after the edge
    task automatic step();
        logic popped;
        #1;
        popped = PIX_READY;
        @(posedge ACLK);
        #1;
        if (popped) begin
            pix_word = pix_word + 36'd1;
            n_pops++;
        end
        PIX_DATA = pix_word;
    endtask

    // Expected {de, hsync, vsync, frame_start, underrun, data} for position (h, v)
    function automatic logic [40:0] exp_out(input int h, input int v, input logic vld,
                                            input logic [35:0] word);
        logic act, hsr, vsr;
        logic [35:0] d;
        act = (h < e_ha) && (v < e_va);
        hsr = (h >= e_ha + e_hfp) && (h < e_ha + e_hfp + e_hs);
        vsr = (v >= e_va + e_vfp) && (v < e_va + e_vfp + e_vs);
        d   = !act ? 36'd0 : (vld ? word : UC);
        return {act, hsr ? e_hp : ~e_hp, vsr ? e_vp : ~e_vp,
                act && h == 0 && v == 0, act && !vld, d};
    endfunction

    task automatic set_cfg(input logic hp, input logic vp);
        H_ACTIVE = 12'd4; H_FP = 12'd1; H_SYNC = 12'd2; H_BP = 12'd1;
        V_ACTIVE = 12'd3; V_FP = 12'd1; V_SYNC = 12'd1; V_BP = 12'd1;
        H_POL = hp; V_POL = vp;
        e_ha = 4; e_hfp = 1; e_hs = 2; e_hbp = 1;
        e_va = 3; e_vfp = 1; e_vs = 1; e_vbp = 1;
        e_hp = hp; e_vp = vp;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        EN = 1'b0;
        PIX_VALID = 1'b1;
        pix_word = 36'd0;
        exp_word = 36'd0;
        PIX_DATA = 36'd0;
        n_pops = 0;
        step();
        step();
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        set_cfg(1'b1, 1'b1);
        nRST = 1'b0;
        EN = 1'b1;
        PIX_VALID = 1'b1;
        PIX_DATA = 36'h123456789;
        step();
        step();
        checks++;
        if ({HDMI_DE, HDMI_HSYNC, HDMI_VSYNC, HDMI_DATA, FRAME_START, UNDERRUN, BUSY,
             PIX_READY} !== 42'd0) begin
            errors++;
            $display("FAIL reset_outputs got de=%b hs=%b vs=%b data=%h fs=%b ur=%b busy=%b rdy=%b exp all 0",
                     HDMI_DE, HDMI_HSYNC, HDMI_VSYNC, HDMI_DATA, FRAME_START, UNDERRUN,
                     BUSY, PIX_READY);
        end
    endtask

    task automatic test_basic_frame();
        logic [40:0] e, got;
        int h, v, fs_cnt;
        do_reset();
        set_cfg(1'b1, 1'b1);
        step();
        EN = 1'b1;
        step();
        checks++;
        if (BUSY !== 1'b1 || PIX_READY !== 1'b1 || HDMI_DE !== 1'b0) begin
            errors++;
            $display("FAIL basic_start got busy=%b rdy=%b de=%b exp 1 1 0", BUSY, PIX_READY,
                     HDMI_DE);
        end
        fs_cnt = 0;
        for (int k = 0; k < 96; k++) begin
            h = k % 8;
            v = (k / 8) % 6;
            step();
            e = exp_out(h, v, 1'b1, exp_word);
            if (e[40]) exp_word = exp_word + 36'd1;
            got = {HDMI_DE, HDMI_HSYNC, HDMI_VSYNC, FRAME_START, UNDERRUN, HDMI_DATA};
            if (FRAME_START) fs_cnt++;
            checks++;
            if (got !== e || BUSY !== 1'b1) begin
                errors++;
                $display("FAIL basic_frame k=%0d got=%h busy=%b exp=%h busy=1", k, got, BUSY, e);
            end
        end
        checks++;
        if (fs_cnt !== 2 || n_pops !== 24) begin
            errors++;
            $display("FAIL basic_counts got fs=%0d pops=%0d exp fs=2 pops=24", fs_cnt, n_pops);
        end
    endtask

    task automatic test_polarity();
        logic [40:0] e, got;
        do_reset();
        set_cfg(1'b0, 1'b0);
        step();
        checks++;
        if (HDMI_HSYNC !== 1'b1 || HDMI_VSYNC !== 1'b1 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL pol_idle got hs=%b vs=%b busy=%b exp 1 1 0", HDMI_HSYNC, HDMI_VSYNC,
                     BUSY);
        end
        EN = 1'b1;
        step();
        for (int k = 0; k < 48; k++) begin
            step();
            e = exp_out(k % 8, k / 8, 1'b1, exp_word);
            if (e[40]) exp_word = exp_word + 36'd1;
            got = {HDMI_DE, HDMI_HSYNC, HDMI_VSYNC, FRAME_START, UNDERRUN, HDMI_DATA};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL pol_frame k=%0d got=%h exp=%h", k, got, e);
            end
        end
    endtask

    task automatic test_underrun();
        logic [40:0] e, got;
        logic vld;
        int ur_cnt;
        do_reset();
        set_cfg(1'b1, 1'b1);
        EN = 1'b1;
        step();
        ur_cnt = 0;
        for (int k = 0; k < 48; k++) begin
            // Line 1, pixel 2 finds the FIFO empty
            vld = (k != 10);
            PIX_VALID = vld;
            step();
            e = exp_out(k % 8, k / 8, vld, exp_word);
            if (e[40] && vld) exp_word = exp_word + 36'd1;
            got = {HDMI_DE, HDMI_HSYNC, HDMI_VSYNC, FRAME_START, UNDERRUN, HDMI_DATA};
            if (UNDERRUN) ur_cnt++;
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL underrun_frame k=%0d got=%h exp=%h", k, got, e);
            end
        end
        PIX_VALID = 1'b1;
        checks++;
        if (ur_cnt !== 1 || n_pops !== 11) begin
            errors++;
            $display("FAIL underrun_counts got ur=%0d pops=%0d exp ur=1 pops=11", ur_cnt, n_pops);
        end
    endtask

    task automatic test_en_drop();
        logic [40:0] e, got;
        do_reset();
        set_cfg(1'b1, 1'b1);
        EN = 1'b1;
        step();
        for (int k = 0; k < 48; k++) begin
            if (k == 11) EN = 1'b0;
            step();
            e = exp_out(k % 8, k / 8, 1'b1, exp_word);
            if (e[40]) exp_word = exp_word + 36'd1;
            got = {HDMI_DE, HDMI_HSYNC, HDMI_VSYNC, FRAME_START, UNDERRUN, HDMI_DATA};
            checks++;
            if (got !== e || BUSY !== (k != 47)) begin
                errors++;
                $display("FAIL endrop_frame k=%0d got=%h busy=%b exp=%h busy=%b", k, got, BUSY,
                         e, (k != 47));
            end
        end
        for (int k = 0; k < 8; k++) begin
            step();
            checks++;
            if (BUSY !== 1'b0 || PIX_READY !== 1'b0 || HDMI_DE !== 1'b0 ||
                HDMI_HSYNC !== 1'b0 || HDMI_VSYNC !== 1'b0) begin
                errors++;
                $display("FAIL endrop_idle k=%0d got busy=%b rdy=%b de=%b hs=%b vs=%b exp all 0",
                         k, BUSY, PIX_READY, HDMI_DE, HDMI_HSYNC, HDMI_VSYNC);
            end
        end
        checks++;
        if (n_pops !== 12) begin
            errors++;
            $display("FAIL endrop_pops got=%0d exp=12", n_pops);
        end
    endtask

    task automatic test_reconfig();
        logic [40:0] e, got;
        do_reset();
        set_cfg(1'b1, 1'b1);
        EN = 1'b1;
        step();
        for (int k = 0; k < 48; k++) begin
            if (k == 5) H_ACTIVE = 12'd6;
            step();
            e = exp_out(k % 8, k / 8, 1'b1, exp_word);
            if (e[40]) exp_word = exp_word + 36'd1;
            got = {HDMI_DE, HDMI_HSYNC, HDMI_VSYNC, FRAME_START, UNDERRUN, HDMI_DATA};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reconfig_old k=%0d got=%h exp=%h", k, got, e);
            end
        end
        e_ha = 6;
        for (int k = 0; k < 60; k++) begin
            step();
            e = exp_out(k % 10, k / 10, 1'b1, exp_word);
            if (e[40]) exp_word = exp_word + 36'd1;
            got = {HDMI_DE, HDMI_HSYNC, HDMI_VSYNC, FRAME_START, UNDERRUN, HDMI_DATA};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reconfig_new k=%0d got=%h exp=%h", k, got, e);
            end
        end
        step();
        checks++;
        if (FRAME_START !== 1'b1 || HDMI_DATA !== 36'd30) begin
            errors++;
            $display("FAIL reconfig_wrap got fs=%b data=%h exp fs=1 data=1e", FRAME_START,
                     HDMI_DATA);
        end
    endtask

    task automatic test_mid_reset();
        logic [40:0] e, got;
        do_reset();
        set_cfg(1'b1, 1'b1);
        EN = 1'b1;
        step();
        step();
        step();
        exp_word = 36'd2;
        nRST = 1'b0;
        #1;
        checks++;
        if (PIX_READY !== 1'b0) begin
            errors++;
            $display("FAIL midreset_ready_low got=%b exp=0", PIX_READY);
        end
        step();
        checks++;
        if ({HDMI_DE, HDMI_HSYNC, HDMI_VSYNC, HDMI_DATA, FRAME_START, UNDERRUN, BUSY,
             PIX_READY} !== 42'd0 || n_pops !== 2) begin
            errors++;
            $display("FAIL midreset_outputs got de=%b hs=%b vs=%b data=%h fs=%b ur=%b busy=%b rdy=%b pops=%0d exp all 0 pops=2",
                     HDMI_DE, HDMI_HSYNC, HDMI_VSYNC, HDMI_DATA, FRAME_START, UNDERRUN,
                     BUSY, PIX_READY, n_pops);
        end
        nRST = 1'b1;
        step();
        checks++;
        if (BUSY !== 1'b1 || HDMI_DE !== 1'b0) begin
            errors++;
            $display("FAIL midreset_restart got busy=%b de=%b exp 1 0", BUSY, HDMI_DE);
        end
        for (int k = 0; k < 48; k++) begin
            step();
            e = exp_out(k % 8, k / 8, 1'b1, exp_word);
            if (e[40]) exp_word = exp_word + 36'd1;
            got = {HDMI_DE, HDMI_HSYNC, HDMI_VSYNC, FRAME_START, UNDERRUN, HDMI_DATA};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL midreset_frame k=%0d got=%h exp=%h", k, got, e);
            end
        end
    endtask

    initial begin
        nRST = 1'b0;
        EN = 1'b0;
        PIX_VALID = 1'b0;
        pix_word = 36'd0;
        exp_word = 36'd0;
        PIX_DATA = 36'd0;
        n_pops = 0;
        set_cfg(1'b1, 1'b1);
        test_reset();
        test_basic_frame();
        test_polarity();
        test_underrun();
        test_en_drop();
        test_reconfig();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
